sccb_target: RTL and testbench

- SCCB responder (camera-side target) emulator. Its bus is the same 2-wire bus that the team's SCCB bridge drives as initiator.
- Oversamples sio_c/sio_d on sccb_clk, decodes start/stop, ID, sub-address and data phases, and holds a 256x8 register file.
- Used for loopback debug and bench verification of the camera control path without a sensor.

---
 rtl/sccb_target.sv | 173 +++++++++++++++++
 tb/tb_sccb_target.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_target.sv
// SCCB target emulator: oversampled start/stop/bit decode with a 256x8 register file.
// Define SCCB_TARGET_ACK_EN to drive an I2C-style ACK in the ninth-bit slot.
`timescale 1ns/1ps
module sccb_target #(
  parameter logic [6:0] DEV_ID  = 7'h21,
  parameter logic [7:0] RST_VAL = 8'h00
) (
  input  logic       sccb_clk,
  input  logic       sccb_reset_n,
  input  logic       sio_c,
  inout  wire        sio_d,
  output logic       wr_strobe,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy,
  input  logic [7:0] dbg_raddr,
  output logic [7:0] dbg_rdata,
  output logic [7:0] debug_out
);

`ifdef SCCB_TARGET_ACK_EN
  localparam logic ACK_EN = 1'b1;
`else
  localparam logic ACK_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ID     = 3'd1,
    S_ADDR   = 3'd2,
    S_WDATA  = 3'd3,
    S_RDATA  = 3'd4,
    S_IGNORE = 3'd5
  } state_t;

  state_t     r_state;
  state_t     w_nextState;
  logic       r_cMeta, r_cSync, r_cHist;
  logic       r_dMeta, r_dSync, r_dHist;
  logic [3:0] r_bitCnt;
  logic [7:0] r_rx;
  logic [7:0] r_tx;
  logic [7:0] r_ptr;
  logic       r_oe;
  logic       r_sdo;
  logic       r_busy;
  logic       r_wrStrobe;
  logic [7:0] r_wrAddr;
  logic [7:0] r_wrData;
  logic [7:0] r_mem [256];

  logic       w_cRise, w_cFall, w_start, w_stop;
  logic       w_byteDone, w_slotDone, w_ackState;
  logic [7:0] w_rxByte;

  assign w_cRise    = r_cSync & ~r_cHist;
  assign w_cFall    = ~r_cSync & r_cHist;
  // Conditions need sio_c stable high, so a coincident clock edge is a data bit.
  assign w_start    = r_cSync & r_cHist & r_dHist & ~r_dSync;
  assign w_stop     = r_cSync & r_cHist & ~r_dHist & r_dSync;
  assign w_rxByte   = {r_rx[6:0], r_dSync};
  assign w_byteDone = w_cRise & (r_bitCnt == 4'd7);
  assign w_slotDone = w_cRise & (r_bitCnt == 4'd8);
  assign w_ackState = ((r_state == S_ID) && (r_rx[7:1] == DEV_ID)) ||
                      (r_state == S_ADDR) || (r_state == S_WDATA);

  assign sio_d      = r_oe ? r_sdo : 1'bz;
  assign wr_strobe  = r_wrStrobe;
  assign wr_addr    = r_wrAddr;
  assign wr_data    = r_wrData;
  assign busy       = r_busy;
  assign dbg_rdata  = r_mem[dbg_raddr];
  assign debug_out  = {r_cSync, r_dSync, r_oe, r_busy, 1'b0, r_state};

  always_comb begin
    w_nextState = r_state;
    if (w_stop) begin
      w_nextState = S_IDLE;
    end else if (w_start) begin
      w_nextState = S_ID;
    end else if (w_slotDone) begin
      case (r_state)
        S_ID: begin
          if (r_rx == {DEV_ID, 1'b0})      w_nextState = S_ADDR;
          else if (r_rx == {DEV_ID, 1'b1}) w_nextState = S_RDATA;
          else                             w_nextState = S_IGNORE;
        end
        S_ADDR:  w_nextState = S_WDATA;
        default: w_nextState = r_state;
      endcase
    end
  end

  always_ff @(posedge sccb_clk or negedge sccb_reset_n) begin
    if (!sccb_reset_n) begin
      r_cMeta    <= 1'b1;
      r_cSync    <= 1'b1;
      r_cHist    <= 1'b1;
      r_dMeta    <= 1'b1;
      r_dSync    <= 1'b1;
      r_dHist    <= 1'b1;
      r_state    <= S_IDLE;
      r_bitCnt   <= 4'd0;
      r_rx       <= 8'h00;
      r_tx       <= 8'h00;
      r_ptr      <= 8'h00;
      r_oe       <= 1'b0;
      r_sdo      <= 1'b0;
      r_busy     <= 1'b0;
      r_wrStrobe <= 1'b0;
      r_wrAddr   <= 8'h00;
      r_wrData   <= 8'h00;
    end else begin
      r_cMeta    <= sio_c;
      r_cSync    <= r_cMeta;
      r_cHist    <= r_cSync;
      r_dMeta    <= sio_d;
      r_dSync    <= r_dMeta;
      r_dHist    <= r_dSync;
      r_state    <= w_nextState;
      r_wrStrobe <= 1'b0;
      if (w_stop) begin
        r_busy   <= 1'b0;
        r_oe     <= 1'b0;
        r_bitCnt <= 4'd0;
      end else if (w_start) begin
        r_busy   <= 1'b1;
        r_oe     <= 1'b0;
        r_bitCnt <= 4'd0;
      end else if (r_state != S_IDLE) begin
        if (w_cRise) begin
          r_bitCnt <= (r_bitCnt == 4'd8) ? 4'd0 : r_bitCnt + 4'd1;
          if (r_bitCnt != 4'd8) r_rx <= w_rxByte;
          if (w_byteDone && (r_state == S_ADDR)) r_ptr <= w_rxByte;
          if (w_byteDone && (r_state == S_WDATA)) begin
            r_wrStrobe <= 1'b1;
            r_wrAddr   <= r_ptr;
            r_wrData   <= w_rxByte;
            r_ptr      <= r_ptr + 8'd1;
          end
          if (w_slotDone && (r_state == S_RDATA)) r_ptr <= r_ptr + 8'd1;
        end else if (w_cFall) begin
          // Falling edge with bit_cnt==0 in RDATA ends a ninth-bit slot: present the next byte.
          if ((r_state == S_RDATA) && (r_bitCnt == 4'd0)) begin
            r_oe  <= 1'b1;
            r_sdo <= r_mem[r_ptr][7];
            r_tx  <= {r_mem[r_ptr][6:0], 1'b0};
          end else if ((r_state == S_RDATA) && (r_bitCnt != 4'd8)) begin
            r_sdo <= r_tx[7];
            r_tx  <= {r_tx[6:0], 1'b0};
          end else if (r_bitCnt == 4'd8) begin
            r_oe  <= ACK_EN & w_ackState;
            r_sdo <= 1'b0;
          end else begin
            r_oe  <= 1'b0;
          end
        end
      end
    end
  end

  // Register file commits the cycle after the strobe, so dbg_rdata follows one cycle later.
  for (genvar g = 0; g < 256; g++) begin : g_mem
    always_ff @(posedge sccb_clk or negedge sccb_reset_n) begin
      if (!sccb_reset_n) begin
        r_mem[g] <= RST_VAL;
      end else if (r_wrStrobe && (r_wrAddr == 8'(g))) begin
        r_mem[g] <= r_wrData;
      end
    end
  end

endmodule

// File: tb/tb_sccb_target.sv
// Directed bench for sccb_target: table-driven write transactions plus read, wrap,
// partial-byte and reset-during-read sequences on an emulated open-drain bus.
`timescale 1ns/1ps
module tb_sccb_target;

`ifdef SCCB_TARGET_ACK_EN
  localparam bit ACK_ON = 1'b1;
`else
  localparam bit ACK_ON = 1'b0;
`endif

  typedef struct {
    logic [7:0] id;
    logic [7:0] addr;
    logic [7:0] data;
    int         expStrobes;
    logic [7:0] expRead;
  } vec_t;

  logic       sccb_clk = 1'b0;
  logic       sccb_reset_n;
  logic       sioC;
  logic       mDrive;
  logic       mVal;
  logic [7:0] dbg_raddr;
  wire        sio_d;
  logic       wr_strobe;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic [7:0] dbg_rdata;
  logic [7:0] debug_out;

  int         compared = 0;
  int         mismatched = 0;
  int         strobeCnt = 0;
  int         oeCycles = 0;
  logic [7:0] sAddr [4];
  logic [7:0] sData [4];
  vec_t       vecs [5];

  assign sio_d = mDrive ? mVal : 1'bz;
  pullup (sio_d);

  sccb_target dut (
    .sccb_clk     (sccb_clk),
    .sccb_reset_n (sccb_reset_n),
    .sio_c        (sioC),
    .sio_d        (sio_d),
    .wr_strobe    (wr_strobe),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .busy         (busy),
    .dbg_raddr    (dbg_raddr),
    .dbg_rdata    (dbg_rdata),
    .debug_out    (debug_out)
  );

  always #5 sccb_clk = ~sccb_clk;

  always @(negedge sccb_clk) begin
    if (wr_strobe) begin
      if (strobeCnt < 4) begin
        sAddr[strobeCnt] = wr_addr;
        sData[strobeCnt] = wr_data;
      end
      strobeCnt = strobeCnt + 1;
    end
    if (debug_out[5]) oeCycles = oeCycles + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared = compared + 1;
    if (act !== exp) begin
      mismatched = mismatched + 1;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge sccb_clk);
  endtask

  task automatic clearMonitor();
    strobeCnt = 0;
    oeCycles  = 0;
  endtask

  task automatic busStart();
    mDrive = 1'b1;
    mVal   = 1'b1;
    tick(4);
    sioC = 1'b1;
    tick(4);
    mVal = 1'b0;
    tick(4);
    sioC = 1'b0;
    tick(4);
  endtask

  task automatic busStop();
    mDrive = 1'b1;
    mVal   = 1'b0;
    tick(4);
    sioC = 1'b1;
    tick(4);
    mVal = 1'b1;
    tick(8);
  endtask

  task automatic sendBit(input logic b);
    mDrive = 1'b1;
    mVal   = b;
    tick(4);
    sioC = 1'b1;
    tick(8);
    sioC = 1'b0;
    tick(4);
  endtask

  task automatic ackSlot(input string name, input bit expAck);
    logic seen;
    mDrive = 1'b0;
    tick(4);
    sioC = 1'b1;
    tick(4);
    seen = debug_out[5] && (sio_d == 1'b0);
    checkOutput(name, {31'd0, seen}, {31'd0, expAck && ACK_ON});
    tick(4);
    sioC = 1'b0;
    tick(4);
  endtask

  task automatic sendByte(input logic [7:0] v, input string name, input bit expAck);
    for (int i = 7; i >= 0; i--) sendBit(v[i]);
    ackSlot(name, expAck);
  endtask

  task automatic readByte(output logic [7:0] v, output logic oeAll);
    mDrive = 1'b0;
    oeAll  = 1'b1;
    v      = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      tick(4);
      sioC = 1'b1;
      tick(4);
      v[i]  = sio_d;
      oeAll = oeAll & debug_out[5];
      tick(4);
      sioC = 1'b0;
      tick(4);
    end
    tick(4);
    sioC = 1'b1;
    tick(4);
    checkOutput("read bit8 released", {31'd0, debug_out[5]}, 32'd0);
    tick(4);
    sioC = 1'b0;
    tick(4);
  endtask

  // One full write transaction: ID, sub-address, one data byte, stop.
  task automatic applyStimulus(input vec_t v);
    bit matched;
    bit isWrite;
    matched = (v.id[7:1] == 7'h21);
    isWrite = (v.id == 8'h42);
    clearMonitor();
    busStart();
    sendByte(v.id, "ack id", matched);
    sendByte(v.addr, "ack addr", isWrite);
    sendByte(v.data, "ack data", isWrite);
    checkOutput("busy before stop", {31'd0, busy}, 32'd1);
    busStop();
    tick(2);
    checkOutput("busy after stop", {31'd0, busy}, 32'd0);
    checkOutput("state idle", {29'd0, debug_out[2:0]}, 32'd0);
    checkOutput("strobe count", strobeCnt, v.expStrobes);
    if (v.expStrobes > 0) begin
      checkOutput("wr_addr", {24'd0, sAddr[0]}, {24'd0, v.addr});
      checkOutput("wr_data", {24'd0, sData[0]}, {24'd0, v.data});
    end
    checkOutput("oe cycles", oeCycles, (ACK_ON && matched) ? 48 : 0);
    dbg_raddr = v.addr;
    tick(1);
    checkOutput("dbg_rdata", {24'd0, dbg_rdata}, {24'd0, v.expRead});
  endtask

  initial begin
    #2ms;
    $display("[TB] FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [7:0] rd;
    logic       oeAll;

    vecs[0] = '{id: 8'h42, addr: 8'h12, data: 8'h80, expStrobes: 1, expRead: 8'h80};
    vecs[1] = '{id: 8'h42, addr: 8'h13, data: 8'h5A, expStrobes: 1, expRead: 8'h5A};
    vecs[2] = '{id: 8'h42, addr: 8'h20, data: 8'h3C, expStrobes: 1, expRead: 8'h3C};
    vecs[3] = '{id: 8'h60, addr: 8'h12, data: 8'h55, expStrobes: 0, expRead: 8'h80};
    vecs[4] = '{id: 8'h42, addr: 8'h40, data: 8'hC3, expStrobes: 1, expRead: 8'hC3};

    sccb_reset_n = 1'b0;
    sioC         = 1'b1;
    mDrive       = 1'b1;
    mVal         = 1'b1;
    dbg_raddr    = 8'h12;
    tick(3);
    sccb_reset_n = 1'b1;
    tick(4);
    checkOutput("reset wr_strobe", {31'd0, wr_strobe}, 32'd0);
    checkOutput("reset wr_addr", {24'd0, wr_addr}, 32'd0);
    checkOutput("reset wr_data", {24'd0, wr_data}, 32'd0);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset debug_out", {24'd0, debug_out}, 32'hC0);
    checkOutput("reset regfile", {24'd0, dbg_rdata}, 32'd0);

    for (int i = 0; i < 5; i++) applyStimulus(vecs[i]);

    // Two-phase read: set pointer, stop, read 0x12, then a second read proves ptr moved to 0x13.
    busStart();
    sendByte(8'h42, "rd ack id", 1'b1);
    sendByte(8'h12, "rd ack addr", 1'b1);
    busStop();
    busStart();
    sendByte(8'h43, "rd ack rid", 1'b1);
    readByte(rd, oeAll);
    checkOutput("read data 0x12", {24'd0, rd}, 32'h80);
    checkOutput("read oe bits", {31'd0, oeAll}, 32'd1);
    busStop();
    tick(2);
    checkOutput("read stop busy", {31'd0, busy}, 32'd0);
    busStart();
    sendByte(8'h43, "rd2 ack rid", 1'b1);
    readByte(rd, oeAll);
    checkOutput("read data ptr 0x13", {24'd0, rd}, 32'h5A);
    busStop();
    tick(2);
    checkOutput("read2 state idle", {29'd0, debug_out[2:0]}, 32'd0);

    // Pointer wrap from 0xFF to 0x00 across a two-byte burst.
    clearMonitor();
    busStart();
    sendByte(8'h42, "wrap ack id", 1'b1);
    sendByte(8'hFF, "wrap ack addr", 1'b1);
    sendByte(8'hA1, "wrap ack d0", 1'b1);
    sendByte(8'hA2, "wrap ack d1", 1'b1);
    busStop();
    tick(2);
    checkOutput("wrap strobe count", strobeCnt, 2);
    checkOutput("wrap addr0", {24'd0, sAddr[0]}, 32'hFF);
    checkOutput("wrap data0", {24'd0, sData[0]}, 32'hA1);
    checkOutput("wrap addr1", {24'd0, sAddr[1]}, 32'h00);
    checkOutput("wrap data1", {24'd0, sData[1]}, 32'hA2);
    dbg_raddr = 8'hFF;
    tick(1);
    checkOutput("wrap reg FF", {24'd0, dbg_rdata}, 32'hA1);
    dbg_raddr = 8'h00;
    tick(1);
    checkOutput("wrap reg 00", {24'd0, dbg_rdata}, 32'hA2);

    // Stop after four bits of a data byte discards it.
    clearMonitor();
    busStart();
    sendByte(8'h42, "part ack id", 1'b1);
    sendByte(8'h20, "part ack addr", 1'b1);
    for (int i = 0; i < 4; i++) sendBit(1'b1);
    busStop();
    tick(2);
    checkOutput("partial strobes", strobeCnt, 0);
    checkOutput("partial state", {29'd0, debug_out[2:0]}, 32'd0);
    dbg_raddr = 8'h20;
    tick(1);
    checkOutput("partial reg 20", {24'd0, dbg_rdata}, 32'h3C);

    // Reset while the target drives bit 3 of a read byte.
    busStart();
    sendByte(8'h42, "rst ack id", 1'b1);
    sendByte(8'h12, "rst ack addr", 1'b1);
    busStop();
    busStart();
    sendByte(8'h43, "rst ack rid", 1'b1);
    mDrive = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(4);
      sioC = 1'b1;
      tick(8);
      sioC = 1'b0;
      tick(4);
    end
    checkOutput("pre-reset oe", {31'd0, debug_out[5]}, 32'd1);
    checkOutput("pre-reset pad", {31'd0, sio_d}, 32'd0);
    sccb_reset_n = 1'b0;
    #1;
    checkOutput("reset oe", {31'd0, debug_out[5]}, 32'd0);
    checkOutput("reset pad released", {31'd0, sio_d}, 32'd1);
    checkOutput("reset2 wr_data", {24'd0, wr_data}, 32'd0);
    checkOutput("reset2 busy", {31'd0, busy}, 32'd0);
    checkOutput("reset2 state", {29'd0, debug_out[2:0]}, 32'd0);
    dbg_raddr = 8'h12;
    #1;
    checkOutput("reset2 regfile", {24'd0, dbg_rdata}, 32'd0);
    sioC   = 1'b1;
    mDrive = 1'b1;
    mVal   = 1'b1;
    tick(2);
    sccb_reset_n = 1'b1;
    tick(4);
    checkOutput("post-reset debug_out", {24'd0, debug_out}, 32'hC0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
